// File: rtl/wish_unpack_pkg.sv
// Shared encodings for the wishbone pack/unpack bridges.
// State values and endian selectors common to both directions.
package wish_unpack_pkg;

  typedef enum logic {
    WISH_IDLE = 1'b0,
    WISH_SEND = 1'b1
  } wish_state_e;

  localparam int WISH_LITTLE = 1;
  localparam int WISH_BIG    = 0;

endpackage

// File: rtl/wish_unpack.sv
// Wishbone bridge: splits one wide source word into NUM_PACK
// narrow beats presented in turn on the destination port.
module wish_unpack #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 1,
  parameter int TGC_ON_ALL    = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o
);

  import wish_unpack_pkg::*;

  localparam int CW = $clog2(NUM_PACK);
  localparam int WW = DATA_WIDTH * NUM_PACK;
  localparam logic [CW-1:0] LAST = CW'(NUM_PACK - 1);

  wish_state_e          state;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        nxt;
  logic [WW-1:0]        buf_q;
  logic [TGC_WIDTH-1:0] tag_q;
  logic                 last;
  logic                 drain;
  logic                 free;

  function automatic logic [DATA_WIDTH-1:0] slice(
    input logic [WW-1:0] w,
    input logic [CW-1:0] k
  );
    logic [CW-1:0] j;
    j = (LITTLE_ENDIAN == WISH_LITTLE) ? k : LAST - k;
    return w[j*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic [TGC_WIDTH-1:0] beat_tag(
    input logic [TGC_WIDTH-1:0] t,
    input logic [CW-1:0]        k
  );
    return (TGC_ON_ALL != 0 || k == LAST) ? t : '0;
  endfunction

  assign nxt       = cnt + CW'(1);
  assign last      = (state == WISH_SEND) && (cnt == LAST);
  assign drain     = d_stb_o & d_ack_i;
  // The last beat leaving frees the buffer in the same cycle.
  assign free      = (state == WISH_IDLE) || (last && drain);
  assign s_ack_o   = s_stb_i & s_cyc_i & rst_n_i & free;
  assign s_stall_o = s_cyc_i & s_stb_i & ~free;
  assign d_cyc_o   = d_stb_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= WISH_IDLE;
      cnt     <= '0;
      buf_q   <= '0;
      tag_q   <= '0;
      d_stb_o <= 1'b0;
      d_dat_o <= '0;
      d_tgc_o <= '0;
    end else if (s_ack_o) begin
      state   <= WISH_SEND;
      cnt     <= '0;
      buf_q   <= s_dat_i;
      tag_q   <= s_tgc_i;
      d_stb_o <= 1'b1;
      d_dat_o <= slice(s_dat_i, '0);
      d_tgc_o <= beat_tag(s_tgc_i, '0);
    end else if (drain) begin
      if (last) begin
        state   <= WISH_IDLE;
        d_stb_o <= 1'b0;
      end else begin
        cnt     <= nxt;
        d_dat_o <= slice(buf_q, nxt);
        d_tgc_o <= beat_tag(tag_q, nxt);
      end
    end
  end

endmodule

// File: tb/tb_wish_unpack.sv
// Bench for wish_unpack: randomized traffic against a beat-queue
// model, one little-endian/all-tag and one big-endian/last-tag DUT.
module tb_wish_unpack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_stb = 1'b0;
  logic        s_cyc = 1'b0;
  logic [31:0] s_dat = '0;
  logic [1:0]  s_tgc = '0;
  logic        d_ack = 1'b0;

  logic       s_ack0, s_stall0, d_stb0, d_cyc0;
  logic [7:0] d_dat0;
  logic [1:0] d_tgc0;
  logic       s_ack1, s_stall1, d_stb1, d_cyc1;
  logic [7:0] d_dat1;
  logic [1:0] d_tgc1;

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] t;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  int    tests = 0;
  int    fails = 0;
  logic  last_acc = 1'b0;

  always #5 clk = ~clk;

  wish_unpack u_le (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .s_stb_i  (s_stb),
    .s_cyc_i  (s_cyc),
    .s_ack_o  (s_ack0),
    .s_stall_o(s_stall0),
    .s_dat_i  (s_dat),
    .s_tgc_i  (s_tgc),
    .d_stb_o  (d_stb0),
    .d_cyc_o  (d_cyc0),
    .d_ack_i  (d_ack),
    .d_dat_o  (d_dat0),
    .d_tgc_o  (d_tgc0)
  );

  wish_unpack #(
    .LITTLE_ENDIAN(0),
    .TGC_ON_ALL   (0)
  ) u_be (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .s_stb_i  (s_stb),
    .s_cyc_i  (s_cyc),
    .s_ack_o  (s_ack1),
    .s_stall_o(s_stall1),
    .s_dat_i  (s_dat),
    .s_tgc_i  (s_tgc),
    .d_stb_o  (d_stb1),
    .d_cyc_o  (d_cyc1),
    .d_ack_i  (d_ack),
    .d_dat_o  (d_dat1),
    .d_tgc_o  (d_tgc1)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // A word becomes four bytes; each DUT flavour orders and tags them.
  task automatic push_word(input logic [31:0] w, input logic [1:0] t);
    beat_t b;
    for (int k = 0; k < 4; k++) begin
      b.d = w[8*k +: 8];
      b.t = t;
      q0.push_back(b);
      b.d = w[8*(3-k) +: 8];
      b.t = (k == 3) ? t : 2'b00;
      q1.push_back(b);
    end
  endtask

  task automatic step(input logic r, input logic stb, input logic cyc,
                      input logic ack, input logic [31:0] w,
                      input logic [1:0] t);
    bit fr;
    bit ea;
    @(posedge clk);
    #1;
    rst_n = r;
    s_stb = stb;
    s_cyc = cyc;
    d_ack = ack;
    s_dat = w;
    s_tgc = t;
    #2;
    if (!r) begin
      chk("ack_in_rst", s_ack0, 0);
      chk("ack_in_rst_be", s_ack1, 0);
      q0.delete();
      q1.delete();
      last_acc = 1'b0;
    end else begin
      fr = (q0.size() == 0) || (q0.size() == 1 && ack);
      ea = stb && cyc && fr;
      chk("d_stb", d_stb0, q0.size() != 0);
      chk("d_cyc", d_cyc0, q0.size() != 0);
      chk("d_stb_be", d_stb1, q1.size() != 0);
      chk("s_ack", s_ack0, ea);
      chk("s_ack_be", s_ack1, ea);
      chk("s_stall", s_stall0, stb && cyc && !fr);
      if (ea) push_word(w, t);
      last_acc = ea;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (d_stb0) begin
        if (q0.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_beat got=%0h want=none", d_dat0);
        end else begin
          chk("d_dat", d_dat0, q0[0].d);
          chk("d_tgc", d_tgc0, q0[0].t);
          if (d_ack) void'(q0.pop_front());
        end
      end
      if (d_stb1) begin
        if (q1.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_beat_be got=%0h want=none", d_dat1);
        end else begin
          chk("d_dat_be", d_dat1, q1[0].d);
          chk("d_tgc_be", d_tgc1, q1[0].t);
          if (d_ack) void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] words[2];
    int          idx;
    words[0] = 32'h03020100;
    words[1] = 32'h07060504;

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("rst_d_dat", d_dat0, 0);
    chk("rst_d_tgc", d_tgc0, 0);
    chk("rst_d_stb_be", d_stb1, 0);

    // single word, ack always high
    step(1, 1, 1, 1, 32'hDDCCBBAA, 2'b01);
    repeat (5) step(1, 0, 0, 1, 0, 0);

    // back-to-back words, no gap expected
    idx = 0;
    for (int c = 0; c < 40 && idx < 2; c++) begin
      step(1, 1, 1, 1, words[idx], 2'b10);
      if (last_acc) idx++;
    end
    chk("b2b_accepts", idx, 2);
    repeat (9) step(1, 0, 0, 1, 0, 0);

    // stall on beat BB with a new word on offer
    step(1, 1, 1, 1, 32'hDDCCBBAA, 2'b11);
    step(1, 0, 0, 1, 0, 0);
    repeat (3) step(1, 1, 1, 0, 32'h44332211, 2'b01);
    idx = 0;
    for (int c = 0; c < 20 && idx < 1; c++) begin
      step(1, 1, 1, 1, 32'h44332211, 2'b01);
      if (last_acc) idx++;
    end
    chk("stall_accept", idx, 1);
    repeat (6) step(1, 0, 0, 1, 0, 0);

    // reset in the middle of a word
    step(1, 1, 1, 1, 32'hDDCCBBAA, 2'b01);
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 1, 1, 32'h12345678, 2'b01);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 1, 32'hDDCCBBAA, 2'b10);
    repeat (6) step(1, 0, 0, 1, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      logic r, stb, cyc, ack;
      r   = ($urandom % 200) != 0;
      stb = ($urandom % 4) != 0;
      cyc = stb ? (($urandom % 8) != 0) : 1'($urandom % 2);
      ack = ($urandom % 3) != 0;
      step(r, stb, cyc, ack, $urandom, 2'($urandom));
    end

    repeat (12) step(1, 0, 0, 1, 0, 0);
    chk("drain_le", q0.size(), 0);
    chk("drain_be", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
